freq_cmd_regs: RTL and testbench

- Command decoder and register block directly downstream of the 32-bit SPI peripheral.
- Consumes each received 32-bit word and its one-cycle valid strobe, and executes host commands: read count, read/write gate length, clear, status, ID.
- Drives the 32-bit send word that the peripheral loads at the start of the next SPI message.
- Holds the latest frequency-count snapshot from the gate counter and the gate-length configuration register.

---
 rtl/freqcnt_pkg.sv | 37 +++
 rtl/freq_cmd_timeout.sv | 26 ++
 rtl/freq_cmd_regs.sv | 122 ++++++++++++
 tb/tb_freq_cmd_regs.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/freqcnt_pkg.sv
// Shared opcodes, status layout and FSM encoding for the frequency-counter command block.
package freqcnt_pkg;

    localparam logic [7:0] OP_NOP         = 8'h00;
    localparam logic [7:0] OP_READ_COUNT  = 8'h01;
    localparam logic [7:0] OP_READ_GATE   = 8'h02;
    localparam logic [7:0] OP_WRITE_GATE  = 8'h03;
    localparam logic [7:0] OP_CLEAR       = 8'h04;
    localparam logic [7:0] OP_READ_STATUS = 8'h05;
    localparam logic [7:0] OP_READ_ID     = 8'h06;

    localparam int unsigned STAT_FRESH   = 0;
    localparam int unsigned STAT_OVERRUN = 1;
    localparam int unsigned STAT_ERROR   = 2;

    localparam logic [31:0] BLOCK_ID_DEFAULT = 32'hF0C0_0001;
    localparam logic [31:0] ERR_TAG          = 32'hDEAD_0000;

    typedef enum logic [0:0] {
        S_CMD,
        S_WDATA
    } state_t;

    function automatic logic [31:0] status_word(input logic [7:0] seq,
                                                input logic err,
                                                input logic ovr,
                                                input logic frs);
        logic [31:0] s;
        s = '0;
        s[31:24]      = seq;
        s[STAT_ERROR]   = err;
        s[STAT_OVERRUN] = ovr;
        s[STAT_FRESH]   = frs;
        return s;
    endfunction

endpackage

// File: rtl/freq_cmd_timeout.sv
// Loadable down-counter bounding the wait for the data word of a gate write.
module freq_cmd_timeout (
    input  logic        fastclk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        en,
    output logic        expire
);

    logic [31:0] cnt;

    // Expires on the enabled cycle that finds the counter already at zero.
    assign expire = en && (cnt == '0);

    always_ff @(posedge fastclk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 32'd1;
        end
    end

endmodule

// File: rtl/freq_cmd_regs.sv
// Host command decoder and register block behind the 32-bit SPI peripheral.
module freq_cmd_regs
    import freqcnt_pkg::*;
#(
    parameter logic [31:0] DEFAULT_GATE   = 32'd10_000_000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000,
    parameter logic [31:0] BLOCK_ID       = BLOCK_ID_DEFAULT
) (
    input  logic        fastclk,
    input  logic        rst,
    input  logic [31:0] rcvd_word,
    input  logic        rcvd_word_valid,
    output logic [31:0] send_word,
    input  logic [31:0] count_in,
    input  logic        count_valid,
    output logic [31:0] gate_len,
    output logic        gate_len_wr,
    output logic        counter_clear
);

    state_t      state;
    logic [31:0] count_hold;
    logic [7:0]  seq;
    logic        fresh;
    logic        overrun;
    logic        cmd_error;

    logic [7:0]  opcode;
    logic        tmo_load;
    logic        tmo_en;
    logic        tmo_expire;

    assign opcode   = rcvd_word[31:24];
    assign tmo_load = (state == S_CMD) && rcvd_word_valid && (opcode == OP_WRITE_GATE);
    assign tmo_en   = (state == S_WDATA) && !rcvd_word_valid;

    freq_cmd_timeout u_timeout (
        .fastclk  (fastclk),
        .rst      (rst),
        .load     (tmo_load),
        .load_val (TIMEOUT_CYCLES - 32'd1),
        .en       (tmo_en),
        .expire   (tmo_expire)
    );

    always_ff @(posedge fastclk) begin
        if (rst) begin
            state         <= S_CMD;
            send_word     <= '0;
            gate_len      <= DEFAULT_GATE;
            gate_len_wr   <= 1'b0;
            counter_clear <= 1'b0;
            count_hold    <= '0;
            seq           <= '0;
            fresh         <= 1'b0;
            overrun       <= 1'b0;
            cmd_error     <= 1'b0;
        end else begin
            gate_len_wr   <= 1'b0;
            counter_clear <= 1'b0;

            // Capture first; command actions below override where they collide.
            if (count_valid) begin
                count_hold <= count_in;
                seq        <= seq + 8'd1;
                fresh      <= 1'b1;
                if (fresh) overrun <= 1'b1;
            end

            unique case (state)
                S_CMD: begin
                    if (rcvd_word_valid) begin
                        case (opcode)
                            OP_NOP: send_word <= '0;
                            OP_READ_COUNT: begin
                                send_word <= count_valid ? count_in : count_hold;
                                fresh     <= 1'b0;
                            end
                            OP_READ_GATE: send_word <= gate_len;
                            OP_WRITE_GATE: state <= S_WDATA;
                            OP_CLEAR: begin
                                counter_clear <= 1'b1;
                                count_hold    <= '0;
                                fresh         <= 1'b0;
                                overrun       <= 1'b0;
                                send_word     <= '0;
                            end
                            OP_READ_STATUS: begin
                                send_word <= status_word(seq, cmd_error, overrun, fresh);
                                cmd_error <= 1'b0;
                                // Only an overrun raised by this very capture survives the read.
                                overrun   <= count_valid && fresh;
                            end
                            OP_READ_ID: send_word <= BLOCK_ID;
                            default: begin
                                cmd_error <= 1'b1;
                                send_word <= ERR_TAG | {24'd0, opcode};
                            end
                        endcase
                    end
                end
                S_WDATA: begin
                    if (rcvd_word_valid) begin
                        if (rcvd_word != '0) begin
                            gate_len    <= rcvd_word;
                            gate_len_wr <= 1'b1;
                            send_word   <= rcvd_word;
                        end else begin
                            cmd_error <= 1'b1;
                        end
                        state <= S_CMD;
                    end else if (tmo_expire) begin
                        cmd_error <= 1'b1;
                        state     <= S_CMD;
                    end
                end
                default: state <= S_CMD;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_cmd_regs.sv
// Directed vector bench for freq_cmd_regs with a shortened write timeout.
module tb_freq_cmd_regs;

    localparam logic [31:0] DG  = 32'd10_000_000;
    localparam logic [31:0] G5  = 32'd5_000_000;
    localparam logic [31:0] RID = 32'h0600_0000;
    localparam logic [31:0] RCN = 32'h0100_0000;
    localparam logic [31:0] RGT = 32'h0200_0000;
    localparam logic [31:0] WGT = 32'h0300_0000;
    localparam logic [31:0] CLR = 32'h0400_0000;
    localparam logic [31:0] RST = 32'h0500_0000;
    localparam int unsigned NV  = 29;

    logic        fastclk = 1'b0;
    logic        rst;
    logic [31:0] rcvd_word;
    logic        rcvd_word_valid;
    logic [31:0] send_word;
    logic [31:0] count_in;
    logic        count_valid;
    logic [31:0] gate_len;
    logic        gate_len_wr;
    logic        counter_clear;

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct {
        logic        v;
        logic [31:0] w;
        logic        cv;
        logic [31:0] ci;
        logic [31:0] sw;
        logic [31:0] gl;
        logic        wr;
        logic        clr;
    } vec_t;

    vec_t vecs[NV];

    freq_cmd_regs #(
        .DEFAULT_GATE   (32'd10_000_000),
        .TIMEOUT_CYCLES (32'd16),
        .BLOCK_ID       (32'hF0C0_0001)
    ) dut (
        .fastclk         (fastclk),
        .rst             (rst),
        .rcvd_word       (rcvd_word),
        .rcvd_word_valid (rcvd_word_valid),
        .send_word       (send_word),
        .count_in        (count_in),
        .count_valid     (count_valid),
        .gate_len        (gate_len),
        .gate_len_wr     (gate_len_wr),
        .counter_clear   (counter_clear)
    );

    always #5 fastclk = ~fastclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs away from the edge, then let the edge sample them.
    task automatic step(input logic r, input logic v, input logic [31:0] w,
                        input logic cv, input logic [31:0] ci);
        @(negedge fastclk);
        rst             = r;
        rcvd_word_valid = v;
        rcvd_word       = w;
        count_valid     = cv;
        count_in        = ci;
        @(posedge fastclk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] sw, input logic [31:0] gl,
                           input logic wr, input logic clr);
        chk({tag, ".send_word"}, send_word, sw);
        chk({tag, ".gate_len"}, gate_len, gl);
        chk({tag, ".gate_len_wr"}, {31'd0, gate_len_wr}, {31'd0, wr});
        chk({tag, ".counter_clear"}, {31'd0, counter_clear}, {31'd0, clr});
    endtask

    initial begin
        vecs[0]  = '{1'b1, RID, 1'b0, 32'd0, 32'hF0C0_0001, DG, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 32'd0, 1'b1, 32'd12345, 32'hF0C0_0001, DG, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, RCN, 1'b0, 32'd0, 32'd12345, DG, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, RST, 1'b0, 32'd0, 32'h0100_0000, DG, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'd0, 1'b1, 32'd100, 32'h0100_0000, DG, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 32'd0, 1'b1, 32'd200, 32'h0100_0000, DG, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, RST, 1'b0, 32'd0, 32'h0300_0003, DG, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, RST, 1'b0, 32'd0, 32'h0300_0001, DG, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, RCN, 1'b0, 32'd0, 32'd200, DG, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, RGT, 1'b0, 32'd0, DG, DG, 1'b0, 1'b0};
        vecs[10] = '{1'b1, WGT, 1'b0, 32'd0, DG, DG, 1'b0, 1'b0};
        vecs[11] = '{1'b1, G5, 1'b0, 32'd0, G5, G5, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 32'd0, 1'b0, 32'd0, G5, G5, 1'b0, 1'b0};
        vecs[13] = '{1'b1, WGT, 1'b0, 32'd0, G5, G5, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 32'd0, 1'b0, 32'd0, G5, G5, 1'b0, 1'b0};
        vecs[15] = '{1'b1, RST, 1'b0, 32'd0, 32'h0300_0004, G5, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 32'h7F12_3456, 1'b0, 32'd0, 32'hDEAD_007F, G5, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 32'h0000_0000, 1'b0, 32'd0, 32'd0, G5, 1'b0, 1'b0};
        vecs[18] = '{1'b1, RST, 1'b0, 32'd0, 32'h0300_0004, G5, 1'b0, 1'b0};
        vecs[19] = '{1'b1, CLR, 1'b1, 32'd999, 32'd0, G5, 1'b0, 1'b1};
        vecs[20] = '{1'b0, 32'd0, 1'b0, 32'd0, 32'd0, G5, 1'b0, 1'b0};
        vecs[21] = '{1'b1, RCN, 1'b0, 32'd0, 32'd0, G5, 1'b0, 1'b0};
        vecs[22] = '{1'b1, RST, 1'b0, 32'd0, 32'h0400_0000, G5, 1'b0, 1'b0};
        vecs[23] = '{1'b1, RCN, 1'b1, 32'd77, 32'd77, G5, 1'b0, 1'b0};
        vecs[24] = '{1'b1, RST, 1'b0, 32'd0, 32'h0500_0000, G5, 1'b0, 1'b0};
        vecs[25] = '{1'b0, 32'd0, 1'b1, 32'd5, 32'h0500_0000, G5, 1'b0, 1'b0};
        vecs[26] = '{1'b1, RST, 1'b1, 32'd6, 32'h0600_0001, G5, 1'b0, 1'b0};
        vecs[27] = '{1'b1, RST, 1'b0, 32'd0, 32'h0700_0003, G5, 1'b0, 1'b0};
        vecs[28] = '{1'b1, RST, 1'b0, 32'd0, 32'h0700_0001, G5, 1'b0, 1'b0};

        rst = 1'b1; rcvd_word_valid = 1'b0; rcvd_word = '0; count_valid = 1'b0; count_in = '0;
        repeat (3) step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        chk_all("reset", 32'd0, DG, 1'b0, 1'b0);

        for (int i = 0; i < NV; i++) begin
            step(1'b0, vecs[i].v, vecs[i].w, vecs[i].cv, vecs[i].ci);
            chk_all($sformatf("vec%0d", i), vecs[i].sw, vecs[i].gl, vecs[i].wr, vecs[i].clr);
        end

        // Data word arriving on the last permitted cycle is still accepted.
        step(1'b0, 1'b1, WGT, 1'b0, 32'd0);
        repeat (15) step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 32'd1234, 1'b0, 32'd0);
        chk_all("late_data", 32'd1234, 32'd1234, 1'b1, 1'b0);

        // One cycle more and the write times out; the next word is a command.
        step(1'b0, 1'b1, WGT, 1'b0, 32'd0);
        repeat (16) step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk_all("timeout_idle", 32'd1234, 32'd1234, 1'b0, 1'b0);
        step(1'b0, 1'b1, RCN, 1'b0, 32'd0);
        chk_all("after_timeout", 32'd6, 32'd1234, 1'b0, 1'b0);
        step(1'b0, 1'b1, RST, 1'b0, 32'd0);
        chk("timeout_status", send_word, 32'h0700_0004);

        // Reset in the middle of a write aborts it.
        step(1'b0, 1'b1, WGT, 1'b0, 32'd0);
        repeat (2) step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'd42, 1'b0, 32'd0);
        chk_all("mid_write_reset", 32'd0, DG, 1'b0, 1'b0);
        step(1'b0, 1'b1, RID, 1'b0, 32'd0);
        chk_all("post_reset_id", 32'hF0C0_0001, DG, 1'b0, 1'b0);
        step(1'b0, 1'b1, RST, 1'b0, 32'd0);
        chk("post_reset_status", send_word, 32'h0000_0000);

        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
